conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Front-end controller for the 6x6 binary convolution layer. It takes the eight pushbutton/switch inputs, synchronises and edge-detects the two control buttons, and loads six 6-bit rows into a frame buffer. It then sequences a serial kernel-of-ones multiply-accumulate over all 36 cells, one cell per clock, and presents the sum with busy/ready/done status to the output pins.

## Interface
- `ROWS`, default 6: number of frame rows; also the row-load count.
- `COLS`, default 6: row width in bits; taken from `ui_in[COLS-1:0]`.
- `SYNC_STAGES`, default 2: flip-flop stages on `ui_in` before edge detection; minimum 2.
- `clk` input, 1 bit: single clock; every register is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `ui_in` input, 8 bits: `[5:0]` row data, `[6]` load button, `[7]` start button. All bits are asynchronous.
- `result` output, 6 bits: sum of the last completed convolution, range 0..36.
- `rows_loaded` output, 3 bits: rows currently stored, range 0..6.
- `ready` output, 1 bit: frame complete and compute allowed (READY state).
- `busy` output, 1 bit: high in COMPUTE.
- `done` output, 1 bit: high in DONE.

## Operation
**Input conditioning**
- All 8 `ui_in` bits pass through `SYNC_STAGES` FFs, so data stays aligned with the strobes.
- `load_p` = rising edge of synced bit 6. `start_p` = rising edge of synced bit 7. Each is one cycle wide per press.
- A button held high produces exactly one pulse.

**Frame buffer**
- `frame[r][c]` holds synced bit c of the row captured on the r-th `load_p`.
- The effective kernel is fixed at all ones, so a cell's product is `frame[r][c] & 1`.

**States**
- IDLE: `rows_loaded`=0.
  - `load_p`: write row 0, then go to LOAD.
  - `start_p`: ignored.
- LOAD: `rows_loaded` is 1..5.
  - `load_p`: write row `rows_loaded` and increment. When the count reaches `ROWS`, go to READY.
  - `start_p`: ignored.
- READY:
  - `start_p`: clear acc and idx, go to COMPUTE.
  - `load_p`: ignored (buffer full).
- COMPUTE:
  - Each cycle: acc += `frame[idx/COLS][idx%COLS]`, then idx++.
  - On the cycle that adds idx=35, `result` <= final sum and go to DONE.
  - Both pulses are ignored in this state.
- DONE:
  - `start_p`: recompute on the same frame (go to COMPUTE).
  - `load_p`: clear `rows_loaded` and write the new row 0, then go to LOAD. Buffer rows 1..5 are stale until overwritten.
- Simultaneous `load_p` and `start_p`:
  - READY and DONE: start wins, load is dropped.
  - IDLE and LOAD: load wins, because start is illegal there.

**Widths and holding**
- acc is 6 bits, so no overflow is possible (max 36).
- idx is 6 bits, range 0..35.
- `result` changes only on COMPUTE→DONE. It holds its previous value through LOAD, READY and COMPUTE.

**Reset**
- Asserting `rst_n` low at any time, including mid-COMPUTE, forces IDLE immediately.
- All outputs go to 0. Sync chain, frame buffer, acc and idx are all cleared.
- No partial result is ever published.

## Timing
- A `ui_in` change sampled at edge n gives the pulse during cycle n+`SYNC_STAGES`-1. The action takes effect at edge n+`SYNC_STAGES`.
  - For a load, `rows_loaded` increments after edge n+2 with the default `SYNC_STAGES`=2.
- Start sampled at edge n:
  - `busy`=1 after edge n+2.
  - `done`=1 and `result` valid after edge n+38 (36 cycles in COMPUTE).
  - `busy` falls on the same edge that `done` rises.
- `ready`, `busy` and `done` are mutually exclusive and registered, with no combinational paths from `ui_in`.

## Test plan
- **Reset:** release `rst_n` → `result`=0, `rows_loaded`=0, and `ready`, `busy`, `done` are all 0.
  - Pulse `ui_in[7]` in IDLE → state stays IDLE, `busy` stays 0.
- **All ones:**
  - Load six rows of 6'b111111 → `rows_loaded` steps 1..6 and `ready`=1.
  - Start → `busy` high exactly 36 cycles, then `done`=1 and `result`=36.
- **Mixed pattern:**
  - Load rows 6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, then start → `result`=21.
  - A seventh load in READY → `rows_loaded` stays 6, buffer unchanged.
- **Held and simultaneous buttons:**
  - Hold `ui_in[6]` high for 20 cycles → exactly one row loaded.
  - In DONE, raise bits 6 and 7 together → recompute; `rows_loaded` stays 6 and `result` is unchanged at 21.
- **Reload from DONE:**
  - Load 6'h00 → LOAD with `rows_loaded`=1, and `result` still holds its old value.
  - Load five more rows of 6'h00, then start → `result`=0.
- **Reset mid-compute:**
  - Assert `rst_n` at COMPUTE cycle 17 → all outputs 0 immediately.
  - After release, a full reload and compute gives the correct sum.

Source files
------------

// File: rtl/conv_sequencer.sv
// Front-end for the 6x6 binary convolution: synchronises buttons, loads rows, serially sums the frame.
// Latency: a button edge acts SYNC_STAGES cycles after sampling; the compute takes ROWS*COLS cycles.
// No backpressure: pulses are ignored in states that cannot use them.
module conv_sequencer #(
    parameter int ROWS        = 6,
    parameter int COLS        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [5:0] result,
    output logic [2:0] rows_loaded,
    output logic       ready,
    output logic       busy,
    output logic       done
);

    localparam int         CELLS    = ROWS * COLS;
    localparam logic [2:0] ROWS_L   = 3'(ROWS);
    localparam logic [5:0] LAST_IDX = 6'(CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_READY   = 3'd2,
        S_COMPUTE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0][7:0]   sync_q;
    logic [1:0]                    btn_prev_q;
    logic [CELLS-1:0]              frame_q, frame_d;
    logic [2:0]                    rows_q, rows_d;
    logic [5:0]                    acc_q, acc_d;
    logic [5:0]                    idx_q, idx_d;
    logic [5:0]                    result_q, result_d;
    logic [7:0]                    sync_out;
    logic                          load_p, start_p;
    logic                          cell_bit;
    logic [5:0]                    acc_sum;
    logic                          write_row;
    logic [2:0]                    wr_sel;

    // Every ui_in bit shares the same chain so row data stays aligned with the load strobe.
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign load_p   = sync_out[6] & ~btn_prev_q[0];
    assign start_p  = sync_out[7] & ~btn_prev_q[1];

    // Kernel is all ones, so each cell's product is just the stored bit; idx is row-major r*COLS+c.
    assign cell_bit = frame_q[idx_q];
    assign acc_sum  = acc_q + {5'b0, cell_bit};

    // Synchroniser chain and button history for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            btn_prev_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], ui_in};
            btn_prev_q <= sync_out[7:6];
        end
    end

    // Control and datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            rows_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            rows_q   <= rows_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: start beats load where both are legal, load beats start elsewhere.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        rows_d    = rows_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        result_d  = result_q;
        write_row = 1'b0;
        wr_sel    = rows_q;
        case (state_q)
            S_IDLE: begin
                if (load_p) begin
                    write_row = 1'b1;
                    wr_sel    = 3'd0;
                    rows_d    = 3'd1;
                    state_d   = (ROWS_L == 3'd1) ? S_READY : S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_p) begin
                    write_row = 1'b1;
                    wr_sel    = rows_q;
                    rows_d    = rows_q + 3'd1;
                    state_d   = (rows_d == ROWS_L) ? S_READY : S_LOAD;
                end
            end
            S_READY: begin
                if (start_p) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                acc_d = acc_sum;
                idx_d = idx_q + 6'd1;
                if (idx_q == LAST_IDX) begin
                    result_d = acc_sum;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (start_p) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_COMPUTE;
                end else if (load_p) begin
                    // Rows 1.. stay stale until overwritten by the following loads.
                    write_row = 1'b1;
                    wr_sel    = 3'd0;
                    rows_d    = 3'd1;
                    state_d   = (ROWS_L == 3'd1) ? S_READY : S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (write_row) begin
            for (int r = 0; r < ROWS; r++) begin
                if (3'(r) == wr_sel) begin
                    frame_d[r*COLS +: COLS] = sync_out[COLS-1:0];
                end
            end
        end
    end

    assign result      = result_q;
    assign rows_loaded = rows_q;
    assign ready       = (state_q == S_READY);
    assign busy        = (state_q == S_COMPUTE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: loads frames, runs computes, checks status timing and sums.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Compute waits are bounded by a fixed cycle budget.
module tb_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [5:0] result;
    logic [2:0] rows_loaded;
    logic       ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    conv_sequencer #(.ROWS(6), .COLS(6), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ui_in       (ui_in),
        .result      (result),
        .rows_loaded (rows_loaded),
        .ready       (ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press load with row data held for 'hold' cycles, then release and let the chain settle.
    task automatic load_row(input logic [5:0] d, input int hold);
        @(negedge clk);
        ui_in = {2'b01, d};
        repeat (hold) @(negedge clk);
        ui_in = {2'b00, d};
        repeat (4) @(negedge clk);
    endtask

    // Raise the buttons in 'btns' (bit1=start, bit0=load) and check the full compute timeline.
    task automatic run_compute(input string tag, input logic [1:0] btns,
                               input logic [5:0] exp_res, input logic [5:0] prev_res);
        int busy_cnt;
        @(negedge clk);
        ui_in[7:6] = btns;                 // sampled at edge n
        @(negedge clk);                    // after edge n
        @(negedge clk);                    // after edge n+1
        check({tag, "_busy_n1"}, busy, 0);
        ui_in[7:6] = 2'b00;
        @(negedge clk);                    // after edge n+2
        check({tag, "_busy_n2"}, busy, 1);
        check({tag, "_ready_n2"}, ready, 0);
        check({tag, "_rows_n2"}, rows_loaded, 6);
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            busy_cnt++;
            if (k == 10) check({tag, "_result_hold"}, result, prev_res);
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, busy_cnt, 36);
        check({tag, "_done"}, done, 1);
        check({tag, "_result"}, result, exp_res);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_rows", rows_loaded, 0);
        check("rst_status", {ready, busy, done}, 0);

        // Start in IDLE is ignored
        ui_in[7] = 1'b1;
        repeat (3) @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_start_busy", busy, 0);
        check("idle_start_status", {ready, done, rows_loaded}, 0);

        // All ones frame
        for (int r = 1; r <= 6; r++) begin
            load_row(6'h3F, 3);
            check($sformatf("ones_rows%0d", r), rows_loaded, r);
        end
        check("ones_ready", ready, 1);
        run_compute("ones", 2'b10, 6'd36, 6'd0);

        // Mixed staircase, first row loaded from DONE
        load_row(6'h01, 3);
        check("mix_rows1", rows_loaded, 1);
        check("mix_result_hold", result, 36);
        check("mix_load_state", {ready, busy, done}, 0);
        load_row(6'h03, 3);
        load_row(6'h07, 3);
        load_row(6'h0F, 3);
        load_row(6'h1F, 3);
        load_row(6'h3F, 3);
        check("mix_rows6", rows_loaded, 6);
        check("mix_ready", ready, 1);
        load_row(6'h00, 3);                // seventh load in READY
        check("extra_load_rows", rows_loaded, 6);
        check("extra_load_ready", ready, 1);
        run_compute("mix", 2'b10, 6'd21, 6'd36);

        // Load and start together in DONE: recompute wins
        run_compute("simul", 2'b11, 6'd21, 6'd21);

        // Reload from DONE with a long-held load button
        load_row(6'h00, 20);
        check("held_rows1", rows_loaded, 1);
        check("held_result_hold", result, 21);
        for (int r = 0; r < 5; r++) load_row(6'h00, 3);
        check("zero_rows6", rows_loaded, 6);
        run_compute("zero", 2'b10, 6'd0, 6'd21);

        // Irregular frame: 3+3+6+0+2+2 = 16
        load_row(6'h15, 3);
        load_row(6'h2A, 3);
        load_row(6'h3F, 3);
        load_row(6'h00, 3);
        load_row(6'h21, 3);
        load_row(6'h0C, 3);
        run_compute("irr", 2'b10, 6'd16, 6'd0);

        // Recompute and reset during COMPUTE cycle 17
        @(negedge clk);
        ui_in[7] = 1'b1;
        repeat (2) @(negedge clk);
        ui_in[7] = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1);
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_result", result, 0);
        check("midrst_rows", rows_loaded, 0);
        check("midrst_status", {ready, busy, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_after_release", {result, rows_loaded, ready, busy, done}, 0);

        // Full reload after reset
        load_row(6'h15, 3);
        load_row(6'h2A, 3);
        load_row(6'h3F, 3);
        load_row(6'h00, 3);
        load_row(6'h21, 3);
        load_row(6'h0C, 3);
        check("post_rst_ready", ready, 1);
        run_compute("post_rst", 2'b10, 6'd16, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
